// File: rtl/sync_fifo_flags_if.sv
// Handshake and status bundle for sync_fifo_flags.
// master = producer/consumer side, slave = FIFO side.
interface sync_fifo_flags_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
);
  logic                  flush;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_en;
  logic                  full;
  logic                  almost_full;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  empty;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, wr_data, wr_en, rd_en,
    input  full, almost_full, rd_data, rd_valid,
    input  empty, almost_empty, count,
    input  overflow, underflow
  );

  modport slave (
    input  flush, wr_data, wr_en, rd_en,
    output full, almost_full, rd_data, rd_valid,
    output empty, almost_empty, count,
    output overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, thresholds,
// optional FWFT read, flush and sticky error flags.
module sync_fifo_flags #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic clk,
  input  logic rst,
  sync_fifo_flags_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  full, empty;
  logic                  wr_acc, rd_acc;

  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  assign rd_acc = bus.rd_en && !empty;
  assign wr_acc = bus.wr_en && (!full || bus.rd_en);

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= CW'(AF_THRESH));
  assign bus.almost_empty = (count_q <= CW'(AE_THRESH));
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

  // next-state for pointers, count and error flags
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (bus.wr_en && !wr_acc) ovf_d = 1'b1;
      if (bus.rd_en && !rd_acc) unf_d = 1'b1;
    end
  end

  // control state register
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // storage write; contents survive flush and reset
  always_ff @(posedge clk) begin
    if (wr_acc && !rst && !bus.flush)
      mem_q[wr_ptr_q] <= bus.wr_data;
  end

  if (FWFT != 0) begin : gen_fwft
    assign bus.rd_data  = empty ? '0 : mem_q[rd_ptr_q];
    assign bus.rd_valid = !empty;
  end else begin : gen_std
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    // registered read port, data held when idle
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else if (bus.flush) begin
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) rd_data_q <= mem_q[rd_ptr_q];
      end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
  end
endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: standard and FWFT instances
// driven in lockstep, checked against a queue model.
module tb_sync_fifo_flags;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam int AF = 14;
  localparam int AE = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_flags_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) f0 ();
  sync_fifo_flags_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) f1 ();

  sync_fifo_flags #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0)
  ) u_std (
    .clk(clk), .rst(rst), .bus(f0.slave)
  );

  sync_fifo_flags #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1)
  ) u_fwft (
    .clk(clk), .rst(rst), .bus(f1.slave)
  );

  int ncmp = 0;
  int nerr = 0;

  logic [DW-1:0] q[$];
  bit            m_ovf, m_unf, m_rdv;
  logic [DW-1:0] m_rdd;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    logic [DW-1:0] head;
    n = q.size();
    head = (n > 0) ? q[0] : '0;
    chk("count0",  32'(f0.count), n);
    chk("full0",   32'(f0.full), 32'(n == DEPTH));
    chk("afull0",  32'(f0.almost_full), 32'(n >= AF));
    chk("empty0",  32'(f0.empty), 32'(n == 0));
    chk("aempty0", 32'(f0.almost_empty), 32'(n <= AE));
    chk("ovf0",    32'(f0.overflow), 32'(m_ovf));
    chk("unf0",    32'(f0.underflow), 32'(m_unf));
    chk("rdv0",    32'(f0.rd_valid), 32'(m_rdv));
    chk("rdd0",    32'(f0.rd_data), 32'(m_rdd));
    chk("count1",  32'(f1.count), n);
    chk("full1",   32'(f1.full), 32'(n == DEPTH));
    chk("afull1",  32'(f1.almost_full), 32'(n >= AF));
    chk("empty1",  32'(f1.empty), 32'(n == 0));
    chk("aempty1", 32'(f1.almost_empty), 32'(n <= AE));
    chk("ovf1",    32'(f1.overflow), 32'(m_ovf));
    chk("unf1",    32'(f1.underflow), 32'(m_unf));
    chk("rdv1",    32'(f1.rd_valid), 32'(n > 0));
    chk("rdd1",    32'(f1.rd_data), 32'(head));
  endtask

  task automatic step(input bit w, input bit r,
                      input bit fl, input bit rs,
                      input logic [DW-1:0] d);
    int  n;
    bit  racc, wacc;
    f0.wr_en = w;  f1.wr_en = w;
    f0.rd_en = r;  f1.rd_en = r;
    f0.flush = fl; f1.flush = fl;
    f0.wr_data = d; f1.wr_data = d;
    rst = rs;
    @(posedge clk);
    if (rs) begin
      q.delete();
      m_ovf = 0; m_unf = 0; m_rdv = 0; m_rdd = '0;
    end else if (fl) begin
      q.delete();
      m_ovf = 0; m_unf = 0; m_rdv = 0;
    end else begin
      n = q.size();
      racc = r && (n > 0);
      wacc = w && ((n < DEPTH) || r);
      if (r && !racc) m_unf = 1;
      if (w && !wacc) m_ovf = 1;
      m_rdv = racc;
      if (racc) m_rdd = q.pop_front();
      if (wacc) q.push_back(d);
    end
    #1;
    check_all();
  endtask

  initial begin
    f0.wr_en = 0; f0.rd_en = 0; f0.flush = 0; f0.wr_data = '0;
    f1.wr_en = 0; f1.rd_en = 0; f1.flush = 0; f1.wr_data = '0;
    m_ovf = 0; m_unf = 0; m_rdv = 0; m_rdd = '0;

    step(0, 0, 0, 1, '0);
    step(0, 0, 0, 0, '0);

    for (int i = 1; i <= 16; i++) step(1, 0, 0, 0, DW'(i));
    for (int i = 0; i < 16; i++) step(0, 1, 0, 0, '0);
    step(0, 0, 0, 0, '0);

    for (int i = 0; i < 16; i++) step(1, 0, 0, 0, DW'(16'h100 + i));
    step(1, 0, 0, 0, 16'hBEEF);
    step(0, 0, 0, 0, '0);
    for (int i = 0; i < 16; i++) step(0, 1, 0, 0, '0);
    step(0, 1, 0, 0, '0);
    step(0, 0, 0, 0, '0);

    step(0, 0, 1, 0, '0);
    for (int i = 0; i < 16; i++) step(1, 0, 0, 0, DW'(16'h200 + i));
    step(1, 1, 0, 0, 16'h00AA);
    for (int i = 0; i < 16; i++) step(0, 1, 0, 0, '0);

    step(0, 0, 1, 0, '0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, DW'(16'h300 + i));
    for (int i = 0; i < 40; i++) step(1, 1, 0, 0, DW'($urandom));
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, '0);

    step(1, 0, 0, 0, 16'h1234);
    step(1, 0, 0, 0, 16'h5678);
    step(0, 0, 0, 0, '0);
    step(0, 1, 0, 0, '0);
    step(0, 1, 0, 0, '0);

    for (int i = 0; i < 16; i++) step(1, 0, 0, 0, DW'(16'h400 + i));
    step(1, 0, 0, 0, 16'hDEAD);
    for (int i = 0; i < 9; i++) step(0, 1, 0, 0, '0);
    step(1, 1, 1, 0, 16'h5555);
    step(1, 0, 0, 0, 16'h0042);
    step(0, 1, 0, 0, '0);
    step(0, 0, 0, 0, '0);

    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, DW'(16'h500 + i));
    step(0, 1, 0, 0, '0);
    step(1, 1, 0, 1, 16'h7777);
    step(1, 0, 0, 0, 16'h0099);
    step(0, 1, 0, 0, '0);

    for (int i = 0; i < 3000; i++) begin
      bit w, r, fl, rs;
      int bias;
      bias = ((i / 100) % 2 == 0) ? 75 : 25;
      w  = ($urandom_range(99) < bias);
      r  = ($urandom_range(99) < (100 - bias));
      fl = ($urandom_range(199) == 0);
      rs = ($urandom_range(399) == 0);
      step(w, r, fl, rs, DW'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             ncmp, nerr);
    $finish;
  end
endmodule
